counter: RTL and testbench

- Free-running synchronous up-counter with a programmable step and a programmable modulus.
- Used as the basic timebase/sequence source in the vcpu test infrastructure.
- Exposes the current count plus terminal-count and wrap indications for downstream sequencing logic.

---
 rtl/counter_pkg.sv | 38 +++
 rtl/counter_next.sv | 33 +++
 rtl/counter.sv | 56 +++++
 tb/tb_counter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and the reference next-count function for the counter block.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 8;

    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

    typedef struct packed {
        logic [31:0] next_value;
        logic        overflow;
    } step_result_t;

    // Width-generic model of one counter advance; saturate selects the hold-at-max variant.
    function automatic step_result_t counter_step(
        input logic [31:0] value,
        input int unsigned step,
        input int unsigned max_value,
        input bit          saturate
    );
        step_result_t r;
        logic [32:0]  sum;
        sum = {1'b0, value} + 33'(step);
        if (sum > 33'(max_value)) begin
            if (saturate) begin
                r.next_value = max_value;
                r.overflow   = (value != max_value);
            end else begin
                r.next_value = 32'(sum - 33'(max_value) - 33'd1);
                r.overflow   = 1'b1;
            end
        end else begin
            r.next_value = sum[31:0];
            r.overflow   = saturate && (sum[31:0] == max_value);
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count logic: modulo wrap, or hold at MAX_VALUE when
// COUNTER_SATURATE_EN is defined.
module counter_next
    import counter_pkg::*;
#(
    parameter int          WIDTH     = COUNTER_WIDTH_DEFAULT,
    parameter int unsigned STEP      = 1,
    parameter int unsigned MAX_VALUE = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] next_value,
    output logic             overflow
);

    localparam int            SW     = WIDTH + 1;
    localparam logic [SW-1:0] STEP_W = SW'(STEP);
    localparam logic [SW-1:0] MAX_W  = SW'(MAX_VALUE);

    logic [SW-1:0] sum;

    always_comb begin
        sum = {1'b0, value} + STEP_W;
`ifdef COUNTER_SATURATE_EN
        // The pulse marks the edge that lands on MAX_VALUE from below; once held it stays low.
        overflow   = (sum >= MAX_W) && ({1'b0, value} != MAX_W);
        next_value = (sum > MAX_W) ? MAX_W[WIDTH-1:0] : sum[WIDTH-1:0];
`else
        overflow   = (sum > MAX_W);
        next_value = overflow ? WIDTH'(sum - MAX_W - SW'(1)) : sum[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/counter.sv
// Free-running step/modulus up-counter with terminal and wrap indications.
// Define COUNTER_SATURATE_EN to saturate at MAX_VALUE instead of wrapping.
module counter
    import counter_pkg::*;
#(
    parameter int          WIDTH       = COUNTER_WIDTH_DEFAULT,
    parameter int unsigned STEP        = 1,
    parameter int unsigned MAX_VALUE   = 2**WIDTH - 1,
    parameter int unsigned RESET_VALUE = 0
) (
    output logic [WIDTH-1:0] value,
    input  logic             clk,
    input  logic             reset,
    output logic             terminal,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VALUE);

    if (STEP == 0 || STEP > MAX_VALUE) begin : g_bad_step
        $error("counter: STEP must lie in 1..MAX_VALUE");
    end
    if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
        $error("counter: RESET_VALUE must not exceed MAX_VALUE");
    end
    if ((64'(MAX_VALUE) >> WIDTH) != 64'd0) begin : g_bad_max
        $error("counter: MAX_VALUE must fit in WIDTH bits");
    end

    logic [WIDTH-1:0] next_value;
    logic             overflow;

    counter_next #(
        .WIDTH     (WIDTH),
        .STEP      (STEP),
        .MAX_VALUE (MAX_VALUE)
    ) u_next (
        .value      (value),
        .next_value (next_value),
        .overflow   (overflow)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            value   <= RESET_C;
            wrapped <= 1'b0;
        end else begin
            value   <= next_value;
            wrapped <= overflow;
        end
    end

    assign terminal = (value == MAX_C);

endmodule

// File: tb/tb_counter.sv
// Directed and randomised-reset checks of counter on three parameter sets.
module tb_counter;
    import counter_pkg::*;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   reset = 1'b0;

    count_t     def_value;
    logic       def_terminal, def_wrapped;
    logic [3:0] mod_value;
    logic       mod_terminal, mod_wrapped;
    logic [3:0] sat_value;
    logic       sat_terminal, sat_wrapped;

    int checks = 0;
    int failures = 0;

    counter u_def (
        .value (def_value), .clk (clk), .reset (reset),
        .terminal (def_terminal), .wrapped (def_wrapped)
    );

    counter #(.WIDTH(4), .STEP(3), .MAX_VALUE(9), .RESET_VALUE(2)) u_mod (
        .value (mod_value), .clk (clk), .reset (reset),
        .terminal (mod_terminal), .wrapped (mod_wrapped)
    );

    counter #(.WIDTH(4), .STEP(5)) u_sat (
        .value (sat_value), .clk (clk), .reset (reset),
        .terminal (sat_terminal), .wrapped (sat_wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive reset away from the edge, then sample just after the rising edge.
    task automatic step(input logic r);
        @(negedge clk);
        reset = r;
        @(posedge clk);
        #1;
    endtask

    // Hand-derived sequences for the ten edges after the first release.
    int mod_tab_v[10];
    int mod_tab_w[10];
    int sat_tab_v[10];
    int sat_tab_w[10];

    initial begin
        logic [31:0]  m_def, m_mod, m_sat;
        logic         w_def, w_mod, w_sat;
        logic         r;
        step_result_t res;

`ifdef COUNTER_SATURATE_EN
        mod_tab_v = '{5, 8, 9, 9, 9, 9, 9, 9, 9, 9};
        mod_tab_w = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        sat_tab_v = '{5, 10, 15, 15, 15, 15, 15, 15, 15, 15};
        sat_tab_w = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
`else
        mod_tab_v = '{5, 8, 1, 4, 7, 0, 3, 6, 9, 2};
        mod_tab_w = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
        sat_tab_v = '{5, 10, 15, 4, 9, 14, 3, 8, 13, 2};
        sat_tab_w = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
`endif

        // Reset held for two edges.
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            check("rst_def_value", 32'(def_value), 32'd0);
            check("rst_def_wrapped", 32'(def_wrapped), 32'd0);
            check("rst_def_terminal", 32'(def_terminal), 32'd0);
            check("rst_mod_value", 32'(mod_value), 32'd2);
            check("rst_mod_wrapped", 32'(mod_wrapped), 32'd0);
            check("rst_sat_value", 32'(sat_value), 32'd0);
        end

        // First ten edges after release.
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            check("run_def_value", 32'(def_value), 32'(i + 1));
            check("run_def_terminal", 32'(def_terminal), 32'd0);
            check("run_def_wrapped", 32'(def_wrapped), 32'd0);
            check("run_mod_value", 32'(mod_value), 32'(mod_tab_v[i]));
            check("run_mod_wrapped", 32'(mod_wrapped), 32'(mod_tab_w[i]));
            check("run_mod_terminal", 32'(mod_terminal), 32'(mod_tab_v[i] == 9));
            check("run_sat_value", 32'(sat_value), 32'(sat_tab_v[i]));
            check("run_sat_wrapped", 32'(sat_wrapped), 32'(sat_tab_w[i]));
            check("run_sat_terminal", 32'(sat_terminal), 32'(sat_tab_v[i] == 15));
        end

        // Continue to 260 edges after release, watching the 255 -> 0 boundary.
        for (int k = 11; k <= 260; k++) begin
            step(1'b1);
            if (k >= 254) begin
`ifdef COUNTER_SATURATE_EN
                check("top_def_value", 32'(def_value), (k >= 255) ? 32'd255 : 32'(k));
                check("top_def_wrapped", 32'(def_wrapped), 32'(k == 255));
                check("top_def_terminal", 32'(def_terminal), 32'(k >= 255));
`else
                check("top_def_value", 32'(def_value), 32'(k % 256));
                check("top_def_wrapped", 32'(def_wrapped), 32'(k == 256));
                check("top_def_terminal", 32'(def_terminal), 32'(k == 255));
`endif
            end
        end

        // Reset pulses mid-count; the later ones land at value 12.
        for (int rep = 0; rep < 3; rep++) begin
            step(1'b0);
            check("pulse_def_value", 32'(def_value), 32'd0);
            check("pulse_def_wrapped", 32'(def_wrapped), 32'd0);
            check("pulse_mod_value", 32'(mod_value), 32'd2);
            step(1'b1);
            check("release_def_value", 32'(def_value), 32'd1);
            check("release_mod_value", 32'(mod_value), 32'd5);
            for (int i = 0; i < 11; i++) step(1'b1);
            check("pre_pulse_def_value", 32'(def_value), 32'd12);
        end

        // Random reset toggling against the package reference model.
        step(1'b0);
        m_def = 32'd0; m_mod = 32'd2; m_sat = 32'd0;
        w_def = 1'b0;  w_mod = 1'b0;  w_sat = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            r = ($urandom_range(0, 15) != 0);
            step(r);
            if (!r) begin
                m_def = 32'd0; m_mod = 32'd2; m_sat = 32'd0;
                w_def = 1'b0;  w_mod = 1'b0;  w_sat = 1'b0;
            end else begin
                res = counter_step(m_def, 1, 255, SAT);
                m_def = res.next_value; w_def = res.overflow;
                res = counter_step(m_mod, 3, 9, SAT);
                m_mod = res.next_value; w_mod = res.overflow;
                res = counter_step(m_sat, 5, 15, SAT);
                m_sat = res.next_value; w_sat = res.overflow;
            end
            check("rnd_def_value", 32'(def_value), m_def);
            check("rnd_def_wrapped", 32'(def_wrapped), 32'(w_def));
            check("rnd_def_terminal", 32'(def_terminal), 32'(m_def == 255));
            check("rnd_mod_value", 32'(mod_value), m_mod);
            check("rnd_mod_wrapped", 32'(mod_wrapped), 32'(w_mod));
            check("rnd_sat_value", 32'(sat_value), m_sat);
            check("rnd_sat_wrapped", 32'(sat_wrapped), 32'(w_sat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
